dmem_responder: RTL and testbench

Memory-side responder for the pipelined CPU's data port. It answers the load/store requests the CPU's memory stage issues: address, write data, write strobe, access size, and sign. It returns aligned, extended read data after a fixed, configurable latency and holds the CPU with a stall signal until the access completes. It also flags misaligned accesses, so the pipeline can raise address-error exceptions.

---
 rtl/dmem_pkg.sv | 59 +++++
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane-steering helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [31:0] DMEM_MMIO_ADDR = 32'hFFFF_FFF0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
    } dmem_req_t;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                                input logic sgn, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, byte-enable writes, one-cycle registered read.
module dmem_ram #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: fixed-latency load/store with lane steering and alignment traps.
// Optional DMEM_MMIO_EN maps a read-only cycle counter at DMEM_MMIO_ADDR.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        adel,
    output logic        ades
);

    localparam int unsigned CNT_W = 3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             ready_q, ready_d;
    logic             adel_q, adel_d;
    logic             ades_q, ades_d;

    logic        misal;
    logic        mmio_hit;
    logic        ram_en;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic [31:0] load_word;

    assign misal = misaligned(req_q.size, req_q.addr[1:0]);

`ifdef DMEM_MMIO_EN
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] mmio_q, mmio_d;

    assign mmio_hit = (req_q.addr == DMEM_MMIO_ADDR);

    always_comb begin
        cyc_d  = cyc_q + 32'd1;
        mmio_d = (state_q == ST_ACCESS) ? cyc_q : mmio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q  <= '0;
            mmio_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            mmio_q <= mmio_d;
        end
    end

    assign load_word = mmio_hit ? mmio_q : ram_rdata;
`else
    logic unused_addr_hi;

    assign mmio_hit       = 1'b0;
    assign load_word      = ram_rdata;
    assign unused_addr_hi = ^req_q.addr[31:ADDR_W+2];
`endif

    // Next-state and per-state RAM control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ready_d = 1'b0;
        adel_d  = 1'b0;
        ades_d  = 1'b0;
        ram_en  = 1'b0;
        ram_be  = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    req_d.we    = we;
                    req_d.addr  = addr;
                    req_d.wdata = wdata;
                    req_d.size  = size;
                    req_d.sgn   = sgn;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ACCESS;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ACCESS: begin
                ram_en  = 1'b1;
                if (req_q.we && !misal && !mmio_hit) begin
                    ram_be = byte_en(req_q.size, req_q.addr[1:0]);
                end
                ready_d = 1'b1;
                adel_d  = misal && !req_q.we;
                ades_d  = misal && req_q.we;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b0;
            adel_q  <= 1'b0;
            ades_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            adel_q  <= adel_d;
            ades_q  <= ades_d;
        end
    end

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .be    (ram_be),
        .addr  (req_q.addr[ADDR_W+1:2]),
        .wdata (store_lanes(req_q.size, req_q.wdata)),
        .rdata (ram_rdata)
    );

    assign stall = (state_q == ST_IDLE && en) || state_q == ST_WAIT || state_q == ST_ACCESS;
    assign ready = ready_q;
    assign adel  = adel_q;
    assign ades  = ades_q;
    // Stores and misaligned accesses return zero.
    assign rdata = (ready_q && !req_q.we && !misal)
                 ? load_extend(req_q.size, req_q.addr[1:0], req_q.sgn, load_word) : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 has no wait states, instance 1 has three.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic        chk;
        logic [31:0] rdata;
        logic        adel;
        logic        ades;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        en_s    [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [1:0]  size_s  [2];
    logic        sgn_s   [2];
    logic [31:0] rdata_s [2];
    logic        ready_s [2];
    logic        stall_s [2];
    logic        adel_s  [2];
    logic        ades_s  [2];

    exp_t exp_q [2][$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    logic [31:0] last_rd;
    int          last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : gd
            dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(g == 0 ? 0 : 3)) dut (
                .clk   (clk),
                .rst   (rst_s[g]),
                .en    (en_s[g]),
                .we    (we_s[g]),
                .addr  (addr_s[g]),
                .wdata (wdata_s[g]),
                .size  (size_s[g]),
                .sgn   (sgn_s[g]),
                .rdata (rdata_s[g]),
                .ready (ready_s[g]),
                .stall (stall_s[g]),
                .adel  (adel_s[g]),
                .ades  (ades_s[g])
            );

            // Monitor: pop one expectation per ready pulse.
            always @(negedge clk) begin
                exp_t e;
                if (ready_s[g]) begin
                    if (exp_q[g].size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_ready dut%0d: got ready=1 required none", g);
                    end else begin
                        e = exp_q[g].pop_front();
                        if (e.chk) check($sformatf("rdata dut%0d", g), rdata_s[g], e.rdata);
                        check($sformatf("adel dut%0d", g), 32'(adel_s[g]), 32'(e.adel));
                        check($sformatf("ades dut%0d", g), 32'(ades_s[g]), 32'(e.ades));
                    end
                end
            end
        end
    endgenerate

    // One request on instance d; caller is just after a rising edge.
    task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sg, input logic chk,
                       input logic [31:0] exp_rd, input logic el, input logic es);
        int   k;
        int   st;
        int   wc;
        logic st_resp;
        wc = (d == 0) ? 0 : 3;
        st = 0;
        st_resp = 1'b1;
        exp_q[d].push_back('{chk, exp_rd, el, es});
        we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; size_s[d] = sz; sgn_s[d] = sg;
        en_s[d] = 1'b1;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) last_cyc = cyc;
            if (ready_s[d]) begin
                last_rd = rdata_s[d];
                st_resp = stall_s[d];
                break;
            end
            st += stall_s[d] ? 1 : 0;
            @(posedge clk);
            #1 en_s[d] = 1'b0;
        end
        en_s[d] = 1'b0;
        if (k == 40) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout dut%0d addr %h: got no ready required ready", d, a);
        end else begin
            check($sformatf("latency dut%0d", d), 32'(k), 32'(wc + 2));
            check($sformatf("stall_cycles dut%0d", d), 32'(st), 32'(wc + 2));
            check($sformatf("stall_in_resp dut%0d", d), 32'(st_resp), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   t [3];
        logic [31:0] m1;
        int          c1;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; en_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0;
            wdata_s[i] = '0; size_s[i] = SZ_WORD; sgn_s[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset ready", 32'(ready_s[i]), 32'd0);
            check("reset rdata", rdata_s[i], 32'd0);
            check("reset adel", 32'(adel_s[i]), 32'd0);
            check("reset ades", 32'(ades_s[i]), 32'd0);
            check("reset stall", 32'(stall_s[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // No wait states: lane steering, extension, alignment.
        acc(0, 1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h10, 32'h0, SZ_WORD, 0, 1, 32'hDEADBEEF, 0, 0);
        acc(0, 0, 32'h13, 32'h0, SZ_BYTE, 1, 1, 32'hFFFFFFDE, 0, 0);
        acc(0, 0, 32'h13, 32'h0, SZ_BYTE, 0, 1, 32'h000000DE, 0, 0);
        acc(0, 0, 32'h10, 32'h0, SZ_HALF, 1, 1, 32'hFFFFBEEF, 0, 0);
        acc(0, 0, 32'h12, 32'h0, SZ_HALF, 0, 1, 32'h0000DEAD, 0, 0);
        acc(0, 0, 32'h12, 32'h0, SZ_HALF, 1, 1, 32'hFFFFDEAD, 0, 0);
        acc(0, 1, 32'h11, 32'h12, SZ_BYTE, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h10, 32'h0, SZ_WORD, 0, 1, 32'hDEAD12EF, 0, 0);
        acc(0, 0, 32'h12, 32'h0, SZ_WORD, 0, 1, 32'h0, 1, 0);
        acc(0, 1, 32'h11, 32'h5555, SZ_HALF, 0, 0, 32'h0, 0, 1);
        acc(0, 0, 32'h10, 32'h0, SZ_WORD, 0, 1, 32'hDEAD12EF, 0, 0);
        acc(0, 1, 32'h12, 32'hCAFE, SZ_HALF, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h10, 32'h0, 2'd3, 0, 1, 32'hCAFE12EF, 0, 0);
        acc(0, 0, 32'h11, 32'h0, SZ_BYTE, 1, 1, 32'h00000012, 0, 0);
        acc(0, 0, 32'h10, 32'h0, SZ_BYTE, 1, 1, 32'hFFFFFFEF, 0, 0);
        acc(0, 0, 32'h11, 32'h0, SZ_HALF, 1, 1, 32'h0, 1, 0);
        acc(0, 1, 32'h4010, 32'h11223344, SZ_WORD, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h10, 32'h0, SZ_WORD, 0, 1, 32'h11223344, 0, 0);

        // High address: counter window or plain RAM alias at 0x3FF0.
        acc(0, 1, 32'h3FF0, 32'h0BADF00D, SZ_WORD, 0, 0, 32'h0, 0, 0);
`ifdef DMEM_MMIO_EN
        acc(0, 0, 32'hFFFFFFF0, 32'h0, SZ_WORD, 0, 0, 32'h0, 0, 0);
        m1 = last_rd;
        c1 = last_cyc;
        repeat (7) @(posedge clk);
        #1;
        acc(0, 0, 32'hFFFFFFF0, 32'h0, SZ_WORD, 0, 0, 32'h0, 0, 0);
        check("mmio delta", last_rd - m1, 32'(last_cyc - c1));
        acc(0, 1, 32'hFFFFFFF0, 32'h12345678, SZ_WORD, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h3FF0, 32'h0, SZ_WORD, 0, 1, 32'h0BADF00D, 0, 0);
`else
        m1 = 32'h0;
        c1 = 0;
        acc(0, 1, 32'hFFFFFFF0, 32'h12345678, SZ_WORD, 0, 0, 32'h0, 0, 0);
        acc(0, 0, 32'h3FF0, 32'h0, SZ_WORD, 0, 1, 32'h12345678, 0, 0);
        check("alias readback", last_rd + m1 + 32'(c1), 32'h12345678);
`endif

        // Three wait states: latency, continuous-request throughput, reset in WAIT.
        acc(1, 1, 32'h20, 32'hA5A50F0F, SZ_WORD, 0, 0, 32'h0, 0, 0);
        acc(1, 0, 32'h20, 32'h0, SZ_WORD, 0, 1, 32'hA5A50F0F, 0, 0);
        acc(1, 0, 32'h22, 32'h0, SZ_HALF, 1, 1, 32'hFFFFA5A5, 0, 0);

        for (int i = 0; i < 3; i++) exp_q[1].push_back('{1'b1, 32'hA5A50F0F, 1'b0, 1'b0});
        we_s[1] = 1'b0; addr_s[1] = 32'h20; size_s[1] = SZ_WORD; en_s[1] = 1'b1;
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            @(negedge clk);
            if (ready_s[1]) begin
                t[n] = cyc;
                n++;
            end
        end
        @(posedge clk);
        #1 en_s[1] = 1'b0;
        check("b2b ready count", 32'(n), 32'd3);
        if (n == 3) begin
            check("b2b spacing 1", 32'(t[1] - t[0]), 32'd6);
            check("b2b spacing 2", 32'(t[2] - t[1]), 32'd6);
        end
        repeat (2) @(posedge clk);
        #1;

        we_s[1] = 1'b1; addr_s[1] = 32'h20; wdata_s[1] = 32'hFFFF0000; size_s[1] = SZ_WORD;
        en_s[1] = 1'b1;
        @(posedge clk);
        #1 en_s[1] = 1'b0;
        @(posedge clk);
        #1 rst_s[1] = 1'b1;
        @(posedge clk);
        #1 rst_s[1] = 1'b0;
        @(negedge clk);
        check("stall after mid reset", 32'(stall_s[1]), 32'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            n += ready_s[1] ? 1 : 0;
        end
        check("ready after mid reset", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        acc(1, 0, 32'h20, 32'h0, SZ_WORD, 0, 1, 32'hA5A50F0F, 0, 0);

        repeat (3) @(posedge clk);
        check("pending dut0", 32'(exp_q[0].size()), 32'd0);
        check("pending dut1", 32'(exp_q[1].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
